// File: rtl/dm9000a_pkg.sv
// Shared types and default bus timing for the DM9000A host-bus engine.
package dm9000a_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_RECOVER
    } state_t;

    localparam int DM9000A_T_SETUP   = 1;
    localparam int DM9000A_T_STROBE  = 2;
    localparam int DM9000A_T_HOLD    = 1;
    localparam int DM9000A_T_RECOVER = 2;

    localparam logic CMD_INDEX = 1'b0;
    localparam logic CMD_DATA  = 1'b1;

endpackage

// File: rtl/dm9000a_int_sync.sv
// Interrupt pin synchroniser: polarity normalisation, INT_SYNC-deep chain and rise detect.
module dm9000a_int_sync #(
    parameter int INT_SYNC     = 2,
    parameter int INT_ACT_HIGH = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise
);

    logic [INT_SYNC-1:0] sync;
    logic                norm;

    assign norm  = (INT_ACT_HIGH != 0) ? pin : ~pin;
    assign level = sync[INT_SYNC-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= '0;
            rise <= 1'b0;
        end else begin
            sync <= {sync[INT_SYNC-2:0], norm};
            // Registered alongside the last stage so the pulse lines up with level rising.
            rise <= sync[INT_SYNC-2] & ~sync[INT_SYNC-1];
        end
    end

endmodule

// File: rtl/dm9000a_bus_engine.sv
// Timed CS#/CMD/IOR#/IOW# access engine for the DM9000A, plus interrupt synchronisation.
//   state      | meaning
//   IDLE       | ready for a request, bus released
//   SETUP      | CS#/CMD (and write data) valid ahead of the strobe
//   STROBE     | IOR# or IOW# low; read data sampled on the last edge
//   HOLD       | strobes released, CS#/CMD/data held
//   RECOVER    | CS# high, bus released before the next access
module dm9000a_bus_engine
    import dm9000a_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int T_SETUP      = DM9000A_T_SETUP,
    parameter int T_STROBE     = DM9000A_T_STROBE,
    parameter int T_HOLD       = DM9000A_T_HOLD,
    parameter int T_RECOVER    = DM9000A_T_RECOVER,
    parameter int INT_SYNC     = 2,
    parameter int INT_ACT_HIGH = 1
) (
    input  logic              iDm9000aClk,
    input  logic              iReset,
    input  logic              iReqValid,
    output logic              oReqReady,
    input  logic              iReqWrite,
    input  logic              iReqCmd,
    input  logic [DATA_W-1:0] iReqData,
    output logic              oRspValid,
    output logic [DATA_W-1:0] oRspData,
    output logic              oBusy,
    input  logic [DATA_W-1:0] iBusData,
    output logic [DATA_W-1:0] oBusData,
    output logic              oBusOutEn,
    output logic              oCs,
    output logic              oCmd,
    output logic              oIor,
    output logic              oIow,
    input  logic              iInt,
    output logic              oInt,
    output logic              oIntRise
);

    localparam int T_MAX_SS = (T_SETUP > T_STROBE) ? T_SETUP : T_STROBE;
    localparam int T_MAX_HR = (T_HOLD > T_RECOVER) ? T_HOLD : T_RECOVER;
    localparam int T_MAX    = (T_MAX_SS > T_MAX_HR) ? T_MAX_SS : T_MAX_HR;
    localparam int CNT_W    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [CNT_W-1:0] LD_SETUP   = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_STROBE  = CNT_W'(T_STROBE - 1);
    localparam logic [CNT_W-1:0] LD_HOLD    = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] LD_RECOVER = CNT_W'(T_RECOVER - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             wr;
    logic             cnt_done;

    assign cnt_done  = (cnt == '0);
    assign oReqReady = (state == ST_IDLE) && !iReset;

    always_ff @(posedge iDm9000aClk) begin
        if (iReset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            wr        <= 1'b0;
            oCs       <= 1'b1;
            oCmd      <= CMD_DATA;
            oIor      <= 1'b1;
            oIow      <= 1'b1;
            oBusOutEn <= 1'b0;
            oBusData  <= '0;
            oRspValid <= 1'b0;
            oRspData  <= '0;
            oBusy     <= 1'b0;
        end else begin
            oRspValid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (iReqValid) begin
                        state     <= ST_SETUP;
                        cnt       <= LD_SETUP;
                        wr        <= iReqWrite;
                        oCs       <= 1'b0;
                        oCmd      <= iReqCmd;
                        oBusOutEn <= iReqWrite;
                        oBusData  <= iReqWrite ? iReqData : '0;
                        oBusy     <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (cnt_done) begin
                        state <= ST_STROBE;
                        cnt   <= LD_STROBE;
                        oIor  <= wr;
                        oIow  <= ~wr;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_STROBE: begin
                    if (cnt_done) begin
                        state <= ST_HOLD;
                        cnt   <= LD_HOLD;
                        oIor  <= 1'b1;
                        oIow  <= 1'b1;
                        if (!wr) begin
                            oRspData  <= iBusData;
                            oRspValid <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (cnt_done) begin
                        state     <= ST_RECOVER;
                        cnt       <= LD_RECOVER;
                        oCs       <= 1'b1;
                        oCmd      <= CMD_DATA;
                        oBusOutEn <= 1'b0;
                        oBusData  <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_RECOVER: begin
                    if (cnt_done) begin
                        state <= ST_IDLE;
                        oBusy <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    dm9000a_int_sync #(
        .INT_SYNC     (INT_SYNC),
        .INT_ACT_HIGH (INT_ACT_HIGH)
    ) u_int_sync (
        .clk   (iDm9000aClk),
        .reset (iReset),
        .pin   (iInt),
        .level (oInt),
        .rise  (oIntRise)
    );

endmodule

// File: tb/tb_dm9000a_bus_engine.sv
// Self-checking bench: default-timing instance plus an 8-bit, long-strobe, inverted-interrupt instance.
module tb_dm9000a_bus_engine;

    localparam int TS = 1, TT = 2, TH = 1, TR = 2;
    localparam int PER_A = TS + TT + TH + TR + 1;
    localparam int BTS = 1, BTT = 4, BTH = 1, BTR = 1;
    localparam int PER_B = BTS + BTT + BTH + BTR + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_valid = 0, a_write = 0, a_cmd = 0, a_int = 0;
    logic [15:0] a_data = '0, a_bus_in = '0;
    logic        a_ready, a_rsp_valid, a_busy, a_oe, a_cs, a_cmd_o, a_ior, a_iow, a_int_o, a_rise;
    logic [15:0] a_rsp_data, a_bus_out;

    logic        b_valid = 0, b_write = 0, b_cmd = 0, b_int = 1;
    logic [7:0]  b_data = '0, b_bus_in = '0;
    logic        b_ready, b_rsp_valid, b_busy, b_oe, b_cs, b_cmd_o, b_ior, b_iow, b_int_o, b_rise;
    logic [7:0]  b_rsp_data, b_bus_out;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    dm9000a_bus_engine dut_a (
        .iDm9000aClk(clk), .iReset(rst),
        .iReqValid(a_valid), .oReqReady(a_ready), .iReqWrite(a_write), .iReqCmd(a_cmd),
        .iReqData(a_data), .oRspValid(a_rsp_valid), .oRspData(a_rsp_data), .oBusy(a_busy),
        .iBusData(a_bus_in), .oBusData(a_bus_out), .oBusOutEn(a_oe), .oCs(a_cs), .oCmd(a_cmd_o),
        .oIor(a_ior), .oIow(a_iow), .iInt(a_int), .oInt(a_int_o), .oIntRise(a_rise)
    );

    dm9000a_bus_engine #(
        .DATA_W(8), .T_SETUP(BTS), .T_STROBE(BTT), .T_HOLD(BTH), .T_RECOVER(BTR),
        .INT_SYNC(3), .INT_ACT_HIGH(0)
    ) dut_b (
        .iDm9000aClk(clk), .iReset(rst),
        .iReqValid(b_valid), .oReqReady(b_ready), .iReqWrite(b_write), .iReqCmd(b_cmd),
        .iReqData(b_data), .oRspValid(b_rsp_valid), .oRspData(b_rsp_data), .oBusy(b_busy),
        .iBusData(b_bus_in), .oBusData(b_bus_out), .oBusOutEn(b_oe), .oCs(b_cs), .oCmd(b_cmd_o),
        .oIor(b_ior), .oIow(b_iow), .iInt(b_int), .oInt(b_int_o), .oIntRise(b_rise)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got a=%b b=%b exp 0", a_ready, b_ready);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({a_cs, a_ior, a_iow, a_cmd_o, a_oe, a_rsp_valid, a_busy, a_ready, a_int_o, a_rise}
                !== 10'b1111_0001_00) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 1111000100",
                     {a_cs, a_ior, a_iow, a_cmd_o, a_oe, a_rsp_valid, a_busy, a_ready, a_int_o, a_rise});
        end
        checks++;
        if (a_bus_out !== 16'h0 || a_rsp_data !== 16'h0) begin
            errors++;
            $display("FAIL reset_data got bus=%h rsp=%h exp 0", a_bus_out, a_rsp_data);
        end
        checks++;
        if ({b_cs, b_ior, b_iow, b_oe, b_busy, b_ready, b_int_o} !== 7'b1110010) begin
            errors++;
            $display("FAIL reset_b got %b exp 1110010", {b_cs, b_ior, b_iow, b_oe, b_busy, b_ready, b_int_o});
        end
    endtask

    // Single access on the default instance, checked cycle by cycle against a timing model.
    task automatic run_access_a(input logic write, input logic cmd, input logic [15:0] data,
                                input logic [15:0] bus_val, input string name);
        logic setup, strobe, hold;
        logic [6:0] exp_v, got_v;
        checks++;
        if (a_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready0 got %b exp 1", name, a_ready);
        end
        a_valid = 1; a_write = write; a_cmd = cmd; a_data = data;
        if (!write) exp_q.push_back(bus_val);
        for (int c = 1; c <= PER_A; c++) begin
            tick();
            a_valid = 0; a_write = ~write; a_cmd = ~cmd; a_data = ~data;
            setup  = (c >= 1) && (c <= TS);
            strobe = (c > TS) && (c <= TS + TT);
            hold   = (c > TS + TT) && (c <= TS + TT + TH);
            a_bus_in = strobe ? bus_val : ~bus_val;
            exp_v = {!(setup || strobe || hold), !(!write && strobe), !(write && strobe),
                     write && (setup || strobe || hold), c < PER_A, c == PER_A,
                     !write && (c == TS + TT + 1)};
            got_v = {a_cs, a_ior, a_iow, a_oe, a_busy, a_ready, a_rsp_valid};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL %s_ctrl cyc%0d got cs/ior/iow/oe/busy/rdy/rv=%b exp %b", name, c, got_v, exp_v);
            end
            checks++;
            if (a_cmd_o !== ((setup || strobe || hold) ? cmd : 1'b1)) begin
                errors++;
                $display("FAIL %s_cmd cyc%0d got %b", name, c, a_cmd_o);
            end
            if (write && (setup || strobe || hold)) begin
                checks++;
                if (a_bus_out !== data) begin
                    errors++;
                    $display("FAIL %s_wdata cyc%0d got %h exp %h", name, c, a_bus_out, data);
                end
            end
            if (a_rsp_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s_rsp_unexpected cyc%0d got %h", name, c, a_rsp_data);
                end else if (a_rsp_data !== exp_q[0]) begin
                    errors++;
                    $display("FAIL %s_rdata got %h exp %h", name, a_rsp_data, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
            end
        end
    endtask

    task automatic test_read();
        run_access_a(1'b0, 1'b1, 16'h0000, 16'h0A46, "read");
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL read_rsp_missing pending %0d exp 0", exp_q.size());
        end
    endtask

    task automatic test_write();
        run_access_a(1'b1, 1'b0, 16'h0028, 16'h0000, "write");
        checks++;
        if (a_rsp_data !== 16'h0A46) begin
            errors++;
            $display("FAIL write_keeps_rdata got %h exp 0a46", a_rsp_data);
        end
    endtask

    task automatic test_back_to_back();
        int acc[2];
        int nacc = 0, both = 0, ior_lo = 0, iow_lo = 0;
        a_valid = 1; a_write = 1; a_cmd = 1; a_data = 16'h1111; a_bus_in = 16'h1234;
        for (int c = 0; c <= 20; c++) begin
            if (a_ior === 1'b0 && a_iow === 1'b0) both++;
            if (a_ior === 1'b0) ior_lo++;
            if (a_iow === 1'b0) iow_lo++;
            if (a_rsp_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0 || a_rsp_data !== 16'h1234) begin
                    errors++;
                    $display("FAIL b2b_rdata got %h exp 1234", a_rsp_data);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (a_valid && a_ready) begin
                if (nacc < 2) acc[nacc] = c;
                nacc++;
                if (nacc == 2) exp_q.push_back(16'h1234);
            end
            tick();
            if (nacc == 1) begin a_write = 0; a_cmd = 0; end
            if (nacc >= 2) a_valid = 0;
        end
        checks++;
        if (nacc != 2 || acc[1] - acc[0] != PER_A) begin
            errors++;
            $display("FAIL b2b_period got accepts=%0d gap=%0d exp 2 and %0d", nacc, acc[1] - acc[0], PER_A);
        end
        checks++;
        if (both != 0 || ior_lo != TT || iow_lo != TT) begin
            errors++;
            $display("FAIL b2b_strobes got both=%0d ior=%0d iow=%0d exp 0 %0d %0d", both, ior_lo, iow_lo, TT, TT);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_rsp_missing pending %0d", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_access();
        int rv = 0;
        a_valid = 1; a_write = 1; a_cmd = 0; a_data = 16'hBEEF;
        tick(); a_valid = 0;
        tick();
        checks++;
        if (a_iow !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_pre iow got %b exp 0", a_iow);
        end
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (a_rsp_valid === 1'b1) rv++;
            checks++;
            if ({a_cs, a_iow, a_ior, a_oe, a_busy, a_ready} !== 6'b111000) begin
                errors++;
                $display("FAIL rst_mid cyc%0d got cs/iow/ior/oe/busy/rdy=%b exp 111000",
                         c, {a_cs, a_iow, a_ior, a_oe, a_busy, a_ready});
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (a_ready !== 1'b1 || rv != 0) begin
            errors++;
            $display("FAIL rst_mid_release got ready=%b rsp_pulses=%0d exp 1 0", a_ready, rv);
        end
        tick();
    endtask

    task automatic test_narrow_read();
        logic strobe;
        int ior_lo = 0, nacc = 0, acc1 = 0;
        logic [6:0] exp_v, got_v;
        b_valid = 1; b_write = 0; b_cmd = 1;
        exp_q.push_back(16'h005A);
        for (int c = 1; c <= PER_B; c++) begin
            tick();
            b_write = 1;
            if (c == 1) b_valid = 0;
            strobe = (c > BTS) && (c <= BTS + BTT);
            b_bus_in = strobe ? 8'h5A : 8'hA5;
            if (b_ior === 1'b0) ior_lo++;
            exp_v = {!(c >= 1 && c <= BTS + BTT + BTH), !strobe, 1'b1, 1'b0,
                     c < PER_B, c == PER_B, c == BTS + BTT + 1};
            got_v = {b_cs, b_ior, b_iow, b_oe, b_busy, b_ready, b_rsp_valid};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL narrow_ctrl cyc%0d got %b exp %b", c, got_v, exp_v);
            end
            if (b_rsp_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0 || {8'h00, b_rsp_data} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL narrow_rdata got %h exp 5a", b_rsp_data);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
        end
        checks++;
        if (ior_lo != BTT || exp_q.size() != 0) begin
            errors++;
            $display("FAIL narrow_strobe got ior_low=%0d pending=%0d exp %0d 0", ior_lo, exp_q.size(), BTT);
        end
        // Period: a held request is accepted again PER_B cycles later.
        b_valid = 1; b_write = 1; b_data = 8'h33;
        for (int c = 0; c <= PER_B + 1; c++) begin
            if (b_valid && b_ready) begin
                if (nacc == 1) acc1 = c;
                nacc++;
            end
            tick();
            if (nacc >= 2) b_valid = 0;
        end
        checks++;
        if (nacc != 2 || acc1 != PER_B) begin
            errors++;
            $display("FAIL narrow_period got accepts=%0d gap=%0d exp 2 %0d", nacc, acc1, PER_B);
        end
        repeat (PER_B) tick();
    endtask

    task automatic test_int();
        int rises = 0, highs = 0;
        a_int = 1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            checks++;
            if (a_int_o !== (c >= 2) || a_rise !== (c == 2)) begin
                errors++;
                $display("FAIL int_a cyc%0d got int=%b rise=%b exp %b %b", c, a_int_o, a_rise, c >= 2, c == 2);
            end
        end
        a_int = 0;
        b_int = 0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            checks++;
            if (b_int_o !== (c >= 3) || b_rise !== (c == 3)) begin
                errors++;
                $display("FAIL int_b cyc%0d got int=%b rise=%b exp %b %b", c, b_int_o, b_rise, c >= 3, c == 3);
            end
        end
        b_int = 1;
        repeat (5) tick();
        checks++;
        if (b_int_o !== 1'b0 || a_int_o !== 1'b0) begin
            errors++;
            $display("FAIL int_release got a=%b b=%b exp 0", a_int_o, b_int_o);
        end
        // Sub-period active-low glitch straddling one clock edge.
        #7 b_int = 0;
        #4 b_int = 1;
        @(posedge clk); #1;
        for (int c = 0; c < 8; c++) begin
            if (b_rise === 1'b1) rises++;
            if (b_int_o === 1'b1) highs++;
            tick();
        end
        checks++;
        if (rises > 1 || highs != 1) begin
            errors++;
            $display("FAIL int_glitch got rises=%0d highs=%0d exp <=1 and 1", rises, highs);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_reset_mid_access();
        test_narrow_read();
        test_int();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm9000a_bus_engine.md
Name: dm9000a_bus_engine

Overview:
Parametrised host-bus access engine for the DM9000A Ethernet controller; successor to the plain pin-register stage.
- Converts single-word read/write requests from the Ethernet control logic into timed CS#/CMD/IOR#/IOW# cycles.
- Setup, strobe, hold and recovery timing are programmable, and read data is captured internally.
- Also synchronises the controller interrupt and detects its edges. Sits between the packet TX/RX controllers and the DM9000A pads.

Parameters:
DATA_W, 16, bus width; 8 or 16 (8: upper oBusData bits driven 0, upper oRspData bits 0)
T_SETUP, 1, cycles CS#/CMD/data valid before strobe (>=1)
T_STROBE, 2, cycles IOR#/IOW# held low (>=1)
T_HOLD, 1, cycles CS#/CMD/data held after strobe release (>=1)
T_RECOVER, 2, cycles CS# high with bus released before next access (>=1)
INT_SYNC, 2, interrupt synchroniser flop count (>=2)
INT_ACT_HIGH, 1, 1: iInt active high; 0: active low (oInt is always active high)

Ports:
iDm9000aClk  in  1  sole clock
iReset  in  1  synchronous active-high reset
iReqValid  in  1  access request
oReqReady  out  1  engine idle, request accepted when iReqValid&&oReqReady
iReqWrite  in  1  1 write, 0 read
iReqCmd  in  1  CMD pin value (0 index port, 1 data port)
iReqData  in  DATA_W  write data
oRspValid  out  1  one-cycle pulse, read data valid
oRspData  out  DATA_W  captured read data
oBusy  out  1  access in progress
iBusData  in  DATA_W  data from pads
oBusData  out  DATA_W  data to pads
oBusOutEn  out  1  pad output enable
oCs  out  1  chip select, active low
oCmd  out  1  CMD pin
oIor  out  1  read strobe, active low
oIow  out  1  write strobe, active low
iInt  in  1  raw interrupt pin
oInt  out  1  synchronised interrupt level, active high
oIntRise  out  1  one-cycle pulse on synchronised assertion

Behaviour:
- Reset values (next edge with iReset=1, including mid-access):
  - oCs=oIor=oIow=1, oCmd=1, oBusOutEn=0, oBusData=0.
  - oRspValid=0, oRspData=0, oBusy=0, oReqReady=0 during reset, 1 after.
  - Synchroniser chain and oInt/oIntRise cleared.
  - Any in-flight access is dropped with no response.
- All pad outputs come from flops; no combinational path from request to pads.
- FSM states: IDLE, SETUP, STROBE, HOLD, RECOVER. One down-counter is loaded on each state entry with T_x-1.
- IDLE: oReqReady=1. On accept, latch write/cmd/data and go to SETUP.
- SETUP: oCs=0, oCmd=latched cmd. On write, oBusOutEn=1 and oBusData=latched data. Lasts T_SETUP cycles, then STROBE.
- STROBE: oIow=0 (write) or oIor=0 (read). Lasts T_STROBE cycles.
  - Read: iBusData is sampled on the clock edge that ends the last STROBE cycle, into oRspData.
  - oRspValid=1 for exactly the first HOLD cycle.
- HOLD: strobes high; CS#, CMD and data unchanged. Lasts T_HOLD cycles.
- RECOVER: oCs=1, oBusOutEn=0, oCmd=1. Lasts T_RECOVER cycles, then IDLE.
- Timing:
  - Access occupies T_SETUP+T_STROBE+T_HOLD+T_RECOVER cycles after the accept cycle.
  - Back-to-back period is that sum +1.
  - Defaults: 6 cycles busy, 7-cycle period.
- oBusy=1 in every state except IDLE. oReqReady = IDLE && !iReset.
- Request inputs are ignored while not IDLE, and changes to them mid-access have no effect.
- oRspData holds its last captured value until the next read capture. Writes never alter it.
- oBusOutEn is never 1 during a read or outside SETUP/STROBE/HOLD of a write. There is no bus contention at any transition.
- Interrupt path:
  - iInt is XOR-normalised by INT_ACT_HIGH, then passed through INT_SYNC flops; oInt is the last stage.
  - oIntRise=1 for one cycle when the last stage goes 0->1.
  - Latency from pin to oInt is INT_SYNC cycles. The path is independent of the FSM and is active during accesses.

Decomposition:
- Package dm9000a_pkg:
  - FSM state enum.
  - Default timing constants DM9000A_T_SETUP/STROBE/HOLD/RECOVER.
  - CMD_INDEX=0, CMD_DATA=1.
- Sub-module dm9000a_int_sync: parametrised synchroniser, polarity normalisation and rise detect, instantiated once.

Test Plan:
- Reset: hold iReset 3 cycles mid-STROBE of a write -> next edge oCs=oIow=1, oBusOutEn=0, oBusy=0; no oRspValid.
- Default write, cmd=0, data 0x0028 -> oCs low cycles 1-4 after accept; oIow low cycles 2-3; oBusOutEn=1 and oBusData=0x0028 cycles 1-4; oReqReady high again cycle 7.
- Default read, cmd=1, iBusData=0x0A46 during strobe -> oIor low cycles 2-3; oRspValid single pulse cycle 4 with oRspData=0x0A46; oBusOutEn stays 0.
- Back-to-back: iReqValid held high for a write then a read -> second accept exactly 7 cycles after first; no cycle where oIor and oIow are both 0.
- DATA_W=8, T_STROBE=4, T_RECOVER=1, read with iBusData=0x5A -> oIor low 4 cycles; oRspData=0x5A; period 8 cycles.
- INT_ACT_HIGH=0, INT_SYNC=3: iInt falls at cycle 0 -> oInt=1 at cycle 3, oIntRise pulse at cycle 3 only; a 1-cycle glitch shorter than a clock period after sync still yields at most one pulse.
